// File: rtl/fft_batch_pkg.sv
// Shared state codes, defaults and helpers for the FFT batch sequencer.
// Optional cycle counters are enabled with FFT_BATCH_PERF_EN in fft_batch_ctrl.
package fft_batch_pkg;

   localparam int unsigned DEF_LAUNCH_HOLD = 4;
   localparam int unsigned DEF_TIMEOUT_CYC = 65536;

   // Bit 3 is the error flag, so NEXT and ERR share the 3-bit code 7.
   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_LAUNCH    = 4'd1,
      S_WAIT_LOAD = 4'd2,
      S_KICK      = 4'd3,
      S_RUN       = 4'd4,
      S_UPLOAD    = 4'd5,
      S_WAIT_UP   = 4'd6,
      S_NEXT      = 4'd7,
      S_ERR       = 4'd15
   } state_e;

   function automatic logic [2:0] err_code(input state_e s);
      logic [3:0] v;
      v = s;
      return v[2:0];
   endfunction

   function automatic logic is_wait(input state_e s);
      return (s == S_WAIT_LOAD) || (s == S_RUN) || (s == S_WAIT_UP);
   endfunction

endpackage

// File: rtl/fft_batch_watchdog.sv
// Saturating per-state watchdog; expire is raised on the last allowed cycle.
// TIMEOUT_CYC of 0 disables expiry entirely.
module fft_batch_watchdog
   import fft_batch_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned W = $clog2(TIMEOUT_CYC + 2);
   localparam int unsigned LIM = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
   localparam logic [W-1:0] LIM_V = W'(LIM);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (TIMEOUT_CYC != 0) && en_i && (cnt_q >= LIM_V);

endmodule

// File: rtl/fft_batch_ctrl.sv
// Batch sequencer between the HBM-to-BRAM load stage and the FFT core group.
// Define FFT_BATCH_PERF_EN to add the RUN / WAIT_UP cycle counters.
module fft_batch_ctrl
   import fft_batch_pkg::*;
#(
   parameter int unsigned SIZE_GROUP  = 8,
   parameter int unsigned LAUNCH_HOLD = DEF_LAUNCH_HOLD,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                  sclk,
   input  logic                  rst,
   input  logic                  go,
   input  logic [CNT_W-1:0]      num_batches,
   input  logic [SIZE_GROUP-1:0] core_en,
   output logic                  launch,
   input  logic                  start_load,
   output logic [SIZE_GROUP-1:0] core_start,
   input  logic [SIZE_GROUP-1:0] core_done,
   output logic                  upload,
   input  logic                  done_upload,
   output logic                  busy,
   output logic [CNT_W-1:0]      batch_cnt,
   output logic                  batch_done,
   output logic                  err_timeout,
   output logic [2:0]            err_state
`ifdef FFT_BATCH_PERF_EN
   ,
   output logic [31:0]           perf_run_cyc,
   output logic [31:0]           perf_up_cyc
`endif
);

   localparam int unsigned HW = $clog2(LAUNCH_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LAUNCH_HOLD - 1);

   state_e state_q, state_d;

   logic [HW-1:0]         hold_q, hold_d;
   logic [SIZE_GROUP-1:0] mask_q, mask_d;
   logic [SIZE_GROUP-1:0] seen_q, seen_d;
   logic [SIZE_GROUP-1:0] cstart_q, cstart_d;
   logic [CNT_W-1:0]      target_q, target_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      cnt_inc;
   logic [2:0]            estate_q, estate_d;

   logic launch_q, launch_d;
   logic upload_q, upload_d;
   logic busy_q, busy_d;
   logic bdone_q, bdone_d;
   logic tmo_q, tmo_d;
   logic du_q;

   logic go_acc;
   logic tmo_hit;
   logic more;
   logic du_rise;
   logic wd_expire;
   logic wd_en;

   assign cnt_inc = cnt_q + 1'b1;
   assign more    = cnt_inc < target_q;
   assign du_rise = done_upload & ~du_q;
   assign wd_en   = is_wait(state_q);

   // Counter idles at zero outside the waiting states, so each entry starts fresh.
   fft_batch_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wd (
      .clk_i    (sclk),
      .rst_i    (rst),
      .clr_i    (~wd_en),
      .en_i     (wd_en),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d = state_q;
      go_acc  = 1'b0;
      tmo_hit = 1'b0;
      unique case (state_q)
         S_IDLE, S_ERR: begin
            if (go) begin
               state_d = S_LAUNCH;
               go_acc  = 1'b1;
            end
         end
         S_LAUNCH: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_WAIT_LOAD;
            end
         end
         S_WAIT_LOAD: begin
            if (start_load) begin
               state_d = S_KICK;
            end else if (wd_expire) begin
               state_d = S_ERR;
               tmo_hit = 1'b1;
            end
         end
         S_KICK: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (seen_q == mask_q) begin
               state_d = S_UPLOAD;
            end else if (wd_expire) begin
               state_d = S_ERR;
               tmo_hit = 1'b1;
            end
         end
         S_UPLOAD: begin
            state_d = S_WAIT_UP;
         end
         S_WAIT_UP: begin
            if (du_rise) begin
               state_d = S_NEXT;
            end else if (wd_expire) begin
               state_d = S_ERR;
               tmo_hit = 1'b1;
            end
         end
         S_NEXT: begin
            state_d = more ? S_LAUNCH : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      mask_d   = mask_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      seen_d   = seen_q;
      tmo_d    = tmo_q;
      estate_d = estate_q;
      hold_d   = (state_q == S_LAUNCH) ? hold_q + 1'b1 : '0;
      if (go_acc) begin
         mask_d   = (core_en == '0) ? '1 : core_en;
         target_d = (num_batches == '0) ? CNT_W'(1) : num_batches;
         cnt_d    = '0;
         tmo_d    = 1'b0;
         estate_d = '0;
      end
      // Completions seen during KICK belong to no batch and are dropped.
      if (state_q == S_KICK) begin
         seen_d = '0;
      end else if (state_q == S_RUN) begin
         seen_d = seen_q | (core_done & mask_q);
      end
      if (state_q == S_NEXT) begin
         cnt_d = cnt_inc;
      end
      if (tmo_hit) begin
         tmo_d    = 1'b1;
         estate_d = err_code(state_q);
      end
      launch_d = (state_d == S_LAUNCH);
      upload_d = (state_d == S_UPLOAD);
      cstart_d = (state_d == S_KICK) ? mask_q : '0;
      busy_d   = (state_d != S_IDLE) && (state_d != S_ERR);
      bdone_d  = (state_q == S_NEXT) && !more;
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         hold_q   <= '0;
         mask_q   <= '0;
         seen_q   <= '0;
         cstart_q <= '0;
         target_q <= '0;
         cnt_q    <= '0;
         estate_q <= '0;
         launch_q <= 1'b0;
         upload_q <= 1'b0;
         busy_q   <= 1'b0;
         bdone_q  <= 1'b0;
         tmo_q    <= 1'b0;
         du_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         mask_q   <= mask_d;
         seen_q   <= seen_d;
         cstart_q <= cstart_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         estate_q <= estate_d;
         launch_q <= launch_d;
         upload_q <= upload_d;
         busy_q   <= busy_d;
         bdone_q  <= bdone_d;
         tmo_q    <= tmo_d;
         du_q     <= done_upload;
      end
   end

   assign launch      = launch_q;
   assign upload      = upload_q;
   assign core_start  = cstart_q;
   assign busy        = busy_q;
   assign batch_cnt   = cnt_q;
   assign batch_done  = bdone_q;
   assign err_timeout = tmo_q;
   assign err_state   = estate_q;

`ifdef FFT_BATCH_PERF_EN
   logic [31:0] prun_q, prun_d;
   logic [31:0] pup_q, pup_d;

   always_comb begin
      prun_d = prun_q;
      pup_d  = pup_q;
      if (go_acc) begin
         prun_d = '0;
         pup_d  = '0;
      end else begin
         if ((state_q == S_RUN) && (prun_q != '1)) begin
            prun_d = prun_q + 1'b1;
         end
         if ((state_q == S_WAIT_UP) && (pup_q != '1)) begin
            pup_d = pup_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         prun_q <= '0;
         pup_q  <= '0;
      end else begin
         prun_q <= prun_d;
         pup_q  <= pup_d;
      end
   end

   assign perf_run_cyc = prun_q;
   assign perf_up_cyc  = pup_q;
`endif

endmodule

// File: tb/tb_fft_batch_ctrl.sv
// Directed bench for fft_batch_ctrl with a small load-stage / core model.
// Built with TIMEOUT_CYC=100 so the watchdog case stays short.
module tb_fft_batch_ctrl;

   logic        sclk;
   logic        rst;
   logic        go;
   logic [15:0] num_batches;
   logic [7:0]  core_en;
   logic        launch;
   logic        start_load;
   logic [7:0]  core_start;
   logic [7:0]  core_done;
   logic        upload;
   logic        done_upload;
   logic        busy;
   logic [15:0] batch_cnt;
   logic        batch_done;
   logic        err_timeout;
   logic [2:0]  err_state;
`ifdef FFT_BATCH_PERF_EN
   logic [31:0] perf_run_cyc;
   logic [31:0] perf_up_cyc;
`endif

   int nvec = 0;
   int nerr = 0;

   int lrun = 0;
   int launch_len = 0;
   int l_cyc = 0;
   int cs_cnt = 0;
   int cs_hi = 0;
   int up_cnt = 0;
   int bd_cnt = 0;
   logic [7:0] cs_last = '0;

   int s_l, s_cs, s_hi, s_up, s_bd;
   int used;
   int n;

   fft_batch_ctrl #(
      .SIZE_GROUP  (8),
      .LAUNCH_HOLD (4),
      .TIMEOUT_CYC (100),
      .CNT_W       (16)
   ) dut (
      .sclk        (sclk),
      .rst         (rst),
      .go          (go),
      .num_batches (num_batches),
      .core_en     (core_en),
      .launch      (launch),
      .start_load  (start_load),
      .core_start  (core_start),
      .core_done   (core_done),
      .upload      (upload),
      .done_upload (done_upload),
      .busy        (busy),
      .batch_cnt   (batch_cnt),
      .batch_done  (batch_done),
      .err_timeout (err_timeout),
      .err_state   (err_state)
`ifdef FFT_BATCH_PERF_EN
      ,
      .perf_run_cyc (perf_run_cyc),
      .perf_up_cyc  (perf_up_cyc)
`endif
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   always @(posedge sclk) begin
      #1;
      if (launch) begin
         lrun++;
         l_cyc++;
      end else if (lrun != 0) begin
         launch_len = lrun;
         lrun = 0;
      end
      if (core_start != '0) begin
         cs_cnt++;
         cs_last = core_start;
      end
      if (core_start[7:4] != '0) cs_hi++;
      if (upload) up_cnt++;
      if (batch_done) bd_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic pick(input int sel);
      case (sel)
         0:       return launch;
         1:       return |core_start;
         2:       return upload;
         default: return err_timeout;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int lim);
      int k;
      k = 0;
      while (!pick(sel) && (k < lim)) begin
         @(negedge sclk);
         k++;
      end
      chk(tag, {31'd0, pick(sel)}, 32'd1);
   endtask

   task automatic start(input logic [15:0] nb, input logic [7:0] en);
      num_batches = nb;
      core_en = en;
      go = 1'b1;
      @(negedge sclk);
      go = 1'b0;
   endtask

   task automatic core_pulses(input logic [7:0] dmask, output int u);
      logic [7:0] rem;
      logic [7:0] p;
      rem = dmask;
      u = 0;
      for (int k = 1; k <= 12; k++) begin
         if (rem == '0) break;
         p = '0;
         for (int i = 0; i < 8; i++)
            if (rem[i] && (5 + i == k)) p[i] = 1'b1;
         core_done = p;
         rem = rem & ~p;
         @(negedge sclk);
         u++;
      end
      core_done = '0;
   endtask

   task automatic load_phase();
      wait_for("launch_seen", 0, 20);
      repeat (20) @(negedge sclk);
      start_load = 1'b1;
      @(negedge sclk);
      start_load = 1'b0;
      wait_for("core_start_seen", 1, 10);
   endtask

   task automatic run_batch(input logic [7:0] dmask);
      int u;
      load_phase();
      core_pulses(dmask, u);
      wait_for("upload_seen", 2, 20);
      repeat (3) @(negedge sclk);
      done_upload = 1'b1;
      repeat (2) @(negedge sclk);
      done_upload = 1'b0;
   endtask

   task automatic snap();
      s_l  = l_cyc;
      s_cs = cs_cnt;
      s_hi = cs_hi;
      s_up = up_cnt;
      s_bd = bd_cnt;
   endtask

   initial begin
      rst = 1'b1;
      go = 1'b0;
      num_batches = '0;
      core_en = '0;
      start_load = 1'b0;
      core_done = '0;
      done_upload = 1'b0;
      repeat (3) @(negedge sclk);

      chk("rst_launch", {31'd0, launch}, 32'd0);
      chk("rst_core_start", {24'd0, core_start}, 32'd0);
      chk("rst_upload", {31'd0, upload}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_batch_cnt", {16'd0, batch_cnt}, 32'd0);
      chk("rst_err", {28'd0, err_timeout, err_state}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge sclk);

      // nominal: 2 batches, all cores
      snap();
      start(16'd2, 8'hFF);
      chk("nom_busy", {31'd0, busy}, 32'd1);
      run_batch(8'hFF);
      run_batch(8'hFF);
      repeat (3) @(negedge sclk);
      chk("nom_launch_len", launch_len, 32'd4);
      chk("nom_launch_cyc", l_cyc - s_l, 32'd8);
      chk("nom_cs_pulses", cs_cnt - s_cs, 32'd2);
      chk("nom_cs_val", {24'd0, cs_last}, 32'hFF);
      chk("nom_upload_cyc", up_cnt - s_up, 32'd2);
      chk("nom_batch_done", bd_cnt - s_bd, 32'd1);
      chk("nom_batch_cnt", {16'd0, batch_cnt}, 32'd2);
      chk("nom_idle", {31'd0, busy}, 32'd0);

      // partial mask: only cores 0-3
      snap();
      start(16'd1, 8'h0F);
      run_batch(8'h0F);
      repeat (3) @(negedge sclk);
      chk("part_cs_val", {24'd0, cs_last}, 32'h0F);
      chk("part_cs_hi", cs_hi - s_hi, 32'd0);
      chk("part_upload_cyc", up_cnt - s_up, 32'd1);
      chk("part_batch_done", bd_cnt - s_bd, 32'd1);
      chk("part_batch_cnt", {16'd0, batch_cnt}, 32'd1);

      // zero num_batches / core_en mean 1 batch, all cores
      snap();
      start(16'd0, 8'h00);
      run_batch(8'hFF);
      repeat (3) @(negedge sclk);
      chk("zero_cs_val", {24'd0, cs_last}, 32'hFF);
      chk("zero_batch_done", bd_cnt - s_bd, 32'd1);
      chk("zero_batch_cnt", {16'd0, batch_cnt}, 32'd1);
      chk("zero_idle", {31'd0, busy}, 32'd0);

      // timeout: core 3 never finishes; RUN entered 1 cycle after KICK seen
      start(16'd1, 8'hFF);
      load_phase();
      core_pulses(8'hF7, used);
      n = used;
      while (!err_timeout && (n < 300)) begin
         @(negedge sclk);
         n++;
      end
      chk("tmo_cycles", n, 32'd101);
      chk("tmo_flag", {31'd0, err_timeout}, 32'd1);
      chk("tmo_state", {29'd0, err_state}, 32'd4);
      chk("tmo_busy", {31'd0, busy}, 32'd0);
      repeat (5) @(negedge sclk);
      snap();
      start(16'd1, 8'hFF);
      chk("tmo_clr_flag", {31'd0, err_timeout}, 32'd0);
      chk("tmo_clr_state", {29'd0, err_state}, 32'd0);
      chk("tmo_restart_busy", {31'd0, busy}, 32'd1);
      run_batch(8'hFF);
      repeat (3) @(negedge sclk);
      chk("tmo_restart_done", bd_cnt - s_bd, 32'd1);
      chk("tmo_restart_cnt", {16'd0, batch_cnt}, 32'd1);

      // done_upload already high entering WAIT_UP, spurious start_load in RUN
      snap();
      start(16'd1, 8'hFF);
      load_phase();
      done_upload = 1'b1;
      repeat (2) @(negedge sclk);
      start_load = 1'b1;
      @(negedge sclk);
      start_load = 1'b0;
      core_pulses(8'hFF, used);
      wait_for("stuck_upload_seen", 2, 20);
      repeat (10) @(negedge sclk);
      chk("stuck_busy", {31'd0, busy}, 32'd1);
      chk("stuck_no_done", bd_cnt - s_bd, 32'd0);
      chk("stuck_cnt_held", {16'd0, batch_cnt}, 32'd0);
      done_upload = 1'b0;
      repeat (2) @(negedge sclk);
      done_upload = 1'b1;
      repeat (4) @(negedge sclk);
      done_upload = 1'b0;
      chk("stuck_batch_done", bd_cnt - s_bd, 32'd1);
      chk("stuck_batch_cnt", {16'd0, batch_cnt}, 32'd1);
      chk("stuck_cs_pulses", cs_cnt - s_cs, 32'd1);
      chk("stuck_upload_cyc", up_cnt - s_up, 32'd1);

      // reset in the middle of RUN
      start(16'd3, 8'hFF);
      load_phase();
      repeat (3) @(negedge sclk);
      snap();
      rst = 1'b1;
      #1;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_launch", {31'd0, launch}, 32'd0);
      chk("mrst_core_start", {24'd0, core_start}, 32'd0);
      chk("mrst_upload", {31'd0, upload}, 32'd0);
      chk("mrst_batch", {15'd0, batch_done, batch_cnt}, 32'd0);
      chk("mrst_err", {28'd0, err_timeout, err_state}, 32'd0);
      @(negedge sclk);
      @(negedge sclk);
      rst = 1'b0;
      core_pulses(8'hFF, used);
      done_upload = 1'b1;
      repeat (2) @(negedge sclk);
      done_upload = 1'b0;
      repeat (20) @(negedge sclk);
      chk("mrst_no_upload", up_cnt - s_up, 32'd0);
      chk("mrst_no_kick", cs_cnt - s_cs, 32'd0);
      chk("mrst_no_done", bd_cnt - s_bd, 32'd0);
      chk("mrst_idle", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fft_batch_ctrl.md
Name: fft_batch_ctrl

Overview:
- Batch sequencer directly downstream of the HBM-to-BRAM load stage, on the load/FFT-core boundary.
- Issues `launch` to the load stage, waits for its `start_load` pulse, and kicks the enabled FFT cores.
- Collects per-core completion, then pulses `upload` to the load stage and waits for `done_upload`.
- Repeats for a programmed number of batches, with a watchdog and a sticky error flag.

Parameters:
- SIZE_GROUP, 8, number of FFT cores per group (matches the load stage's BRAM count).
- LAUNCH_HOLD, 4, cycles `launch` is held high; must be ≥3 so the load stage's 2-flop rise detector sees the edge.
- TIMEOUT_CYC, 65536, watchdog limit in cycles per waiting state; 0 disables the watchdog.
- CNT_W, 16, width of the batch counters.

Ports:
- sclk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- go  in  1  one-cycle start request; sampled only in IDLE or ERR.
- num_batches  in  CNT_W  batches to run, latched on `go`; 0 is treated as 1.
- core_en  in  SIZE_GROUP  core enable mask, latched on `go`; all-zero is treated as all-ones.
- launch  out  1  launch level to the load stage.
- start_load  in  1  one-cycle pulse from the load stage: BRAMs are filled.
- core_start  out  SIZE_GROUP  one-cycle start pulse per enabled core.
- core_done  in  SIZE_GROUP  per-core done pulse or level; captured sticky.
- upload  out  1  one-cycle upload request to the load stage.
- done_upload  in  1  write-back complete; rising edge used.
- busy  out  1  high in every state except IDLE and ERR.
- batch_cnt  out  CNT_W  batches completed in the current run.
- batch_done  out  1  one-cycle pulse when the full run ends.
- err_timeout  out  1  sticky; cleared by `go`.
- err_state  out  3  state code at the moment of the timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal latches cleared. Reset mid-operation aborts immediately, and no pulse is emitted afterwards.
- Transitions are registered, so every output is registered.
- IDLE: on `go`, latch `num_batches`/`core_en`, clear `batch_cnt` and the error flags, go to LAUNCH.
- LAUNCH: `launch`=1 for LAUNCH_HOLD cycles, then `launch`=0 and go to WAIT_LOAD.
- WAIT_LOAD: on `start_load`, go to KICK.
  - A `start_load` pulse arriving in any other state is ignored.
- KICK: for one cycle, `core_start` = latched mask; clear `done_seen`; go to RUN.
- RUN: `done_seen |= core_done & mask`. When `done_seen == mask` (evaluated on the registered value), go to UPLOAD.
  - `core_done` asserted during KICK is not captured.
- UPLOAD: `upload`=1 for exactly one cycle, go to WAIT_UP.
  - A single pulse is mandatory: the load stage restarts if it sees `upload` high while idle.
- WAIT_UP: detect `done_upload` rising edge using a 1-flop delay, reset to 0. On the edge, go to NEXT.
  - If `done_upload` is already high on entry, wait for it to fall and rise again.
- NEXT: `batch_cnt`+1.
  - If the new count < latched target: go to LAUNCH.
  - Otherwise: pulse `batch_done`, go to IDLE.
  - `batch_cnt` is held until the next `go`.
- Watchdog:
  - Counter cleared on entry to WAIT_LOAD, RUN or WAIT_UP.
  - If it reaches TIMEOUT_CYC−1 while still in that state: go to ERR, set `err_timeout`, record `err_state`, drop `launch`/`upload`.
  - The counter saturates and never wraps.
- ERR: outputs idle; only `go` (which restarts) or `rst` leaves this state.
- State codes: IDLE 0, LAUNCH 1, WAIT_LOAD 2, KICK 3, RUN 4, UPLOAD 5, WAIT_UP 6, NEXT/ERR 7 (ERR is a separate internal flag bit).
- `batch_cnt` arithmetic is CNT_W bits and never overflows, since the target ≤ 2^CNT_W−1.

Optional Feature:
- Macro FFT_BATCH_PERF_EN.
- With the macro defined, add outputs `perf_run_cyc` and `perf_up_cyc` (32 bits each):
  - They accumulate cycles spent in RUN and in WAIT_UP over the run.
  - Cleared on `go`; saturating.
- Without the macro, the ports and logic are absent.

Decomposition:
- Package fft_batch_pkg holds:
  - the state enum/codes;
  - the default LAUNCH_HOLD and TIMEOUT_CYC;
  - the state-code-to-`err_state` mapping.
- One natural sub-module, fft_batch_watchdog: clear/enable inputs, saturating counter, `expire` output. It is instantiated once.

Test Plan:
- Nominal run: `go` with `num_batches`=2, `core_en`=8'hFF; model returns `start_load` 20 cycles after `launch`, each core's done at 5..12 cycles. Required:
  - `launch` high exactly 4 cycles;
  - `core_start`=8'hFF for 1 cycle;
  - `upload` a single 1-cycle pulse;
  - after the 2nd `done_upload`, `batch_done` pulses once and `batch_cnt`=2.
- Partial mask: `core_en`=8'h0F; only cores 0–3 done. Required: UPLOAD reached; `core_start[7:4]`=0 throughout.
- Zero defaults: `num_batches`=0 and `core_en`=0. Required: run behaves as 1 batch with mask 8'hFF.
- Timeout: TIMEOUT_CYC=100; core 3 never finishes. Required:
  - ERR entered 100 cycles after RUN entry, with `err_timeout`=1 and `err_state`=4;
  - a following `go` clears the error and restarts.
- `done_upload` stuck high on entry to WAIT_UP. Required: no advance until it falls and rises; spurious `start_load` in RUN is ignored.
- Reset mid-RUN. Required: all outputs 0 within the reset assertion; no `upload`/`core_start` pulse after release.
